// File: rtl/hilo_muldiv_if.sv
// EX-stage request/result bundle between the pipeline (master) and the HI/LO
// multiply/divide unit (slave). state_dbg exposes the unit's FSM state.
interface hilo_muldiv_if;
  logic        req_valid;
  logic        is_mult;
  logic        is_multu;
  logic        is_div;
  logic        is_divu;
  logic        hi_wen;
  logic        lo_wen;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  // Handshake: a request is taken on any rising edge where req_valid=1,
  // busy=0 and flush=0; while busy=1 the master holds its request and inputs
  // stable, and the request is taken on the first edge that sees busy=0.
  modport master (
    output req_valid, is_mult, is_multu, is_div, is_divu, hi_wen, lo_wen,
    output a, b, flush,
    input  hi, lo, busy, done, state_dbg
  );

  modport slave (
    input  req_valid, is_mult, is_multu, is_div, is_divu, hi_wen, lo_wen,
    input  a, b, flush,
    output hi, lo, busy, done, state_dbg
  );
endinterface

// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit: fixed-latency 32x32 multiply, radix-2 restoring
// divide, mthi/mtlo, with a registered busy that stalls EX until results land.
module hilo_muldiv #(
  parameter int MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          resetn,
  hilo_muldiv_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [4:0] LAT = MUL_LAT[4:0];

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [32:0] op_a_q, op_a_d;
  logic [32:0] op_b_q, op_b_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic        dz_q, dz_d;

  logic        accept;
  logic        sgn;
  logic [63:0] a64, b64, product;
  logic [32:0] rem_sh;
  logic [31:0] trial;
  logic        fits;

  assign accept = bus.req_valid & ~busy_q & ~bus.flush;

  // Low 64 bits of a sign/zero-extended product equal the two's complement result.
  assign a64     = {{31{op_a_q[32]}}, op_a_q};
  assign b64     = {{31{op_b_q[32]}}, op_b_q};
  assign product = a64 * b64;

  assign rem_sh = {rem_q, quo_q[31]};
  assign trial  = rem_sh[31:0] - dvs_q;
  assign fits   = rem_sh >= {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    sgn     = 1'b0;

    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_MUL: begin
          if (cnt_q == LAT) begin
            {hi_d, lo_d} = product;
            state_d      = S_IDLE;
            cnt_d        = 5'd0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
          end else begin
            cnt_d  = cnt_q + 5'd1;
            busy_d = (cnt_q + 5'd1) < LAT;
          end
        end
        S_DIV: begin
          rem_d = fits ? trial : rem_sh[31:0];
          quo_d = {quo_q[30:0], fits};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = S_FIX;
            cnt_d   = 5'd0;
          end
        end
        S_FIX: begin
          if (dz_q) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = op_a_q[31:0];
          end else begin
            lo_d = q_neg_q ? (32'd0 - quo_q) : quo_q;
            hi_d = r_neg_q ? (32'd0 - rem_q) : rem_q;
          end
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        default: ;
      endcase

      // A new request may land on the same edge a multiply retires (busy is
      // already low then); the younger instruction's writes take precedence.
      if (accept) begin
        if (bus.is_div || bus.is_divu) begin
          sgn     = bus.is_div;
          op_a_d  = {1'b0, bus.a};
          op_b_d  = {1'b0, bus.b};
          dz_d    = (bus.b == 32'd0);
          q_neg_d = sgn & (bus.a[31] ^ bus.b[31]);
          r_neg_d = sgn & bus.a[31];
          quo_d   = (sgn & bus.a[31]) ? (32'd0 - bus.a) : bus.a;
          dvs_d   = (sgn & bus.b[31]) ? (32'd0 - bus.b) : bus.b;
          rem_d   = 32'd0;
          cnt_d   = 5'd0;
          state_d = S_DIV;
          busy_d  = 1'b1;
        end else if (bus.is_mult || bus.is_multu) begin
          sgn     = bus.is_mult;
          op_a_d  = {sgn & bus.a[31], bus.a};
          op_b_d  = {sgn & bus.b[31], bus.b};
          cnt_d   = 5'd1;
          state_d = S_MUL;
          busy_d  = LAT > 5'd1;
        end else if (bus.hi_wen) begin
          hi_d = bus.a;
        end else if (bus.lo_wen) begin
          lo_d = bus.a;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      op_a_q  <= 33'd0;
      op_b_q  <= 33'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: multiply latency, signed/unsigned divide,
// divide-by-zero, held requests, flush and mid-operation reset.
module tb_hilo_muldiv;

  localparam logic [5:0] F_DIV   = 6'b100000;
  localparam logic [5:0] F_DIVU  = 6'b010000;
  localparam logic [5:0] F_MULT  = 6'b001000;
  localparam logic [5:0] F_MULTU = 6'b000100;
  localparam logic [5:0] F_HIW   = 6'b000010;
  localparam logic [5:0] F_LOW   = 6'b000001;

  logic        clk;
  logic        resetn;
  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];

  hilo_muldiv_if bus_if ();

  hilo_muldiv #(.MUL_LAT(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic clear_req();
    bus_if.req_valid = 1'b0;
    {bus_if.is_div, bus_if.is_divu, bus_if.is_mult,
     bus_if.is_multu, bus_if.hi_wen, bus_if.lo_wen} = 6'b0;
    bus_if.a = 32'd0;
    bus_if.b = 32'd0;
  endtask

  task automatic set_req(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus_if.req_valid = 1'b1;
    {bus_if.is_div, bus_if.is_divu, bus_if.is_mult,
     bus_if.is_multu, bus_if.hi_wen, bus_if.lo_wen} = f;
    bus_if.a = a;
    bus_if.b = b;
  endtask

  // Presents a request at a negedge; returns at the negedge inside cycle T0+1.
  task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    set_req(f, a, b);
    @(posedge clk);
    @(negedge clk);
    clear_req();
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus_if.busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus_if.flush = 1'b0;
    clear_req();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_if.hi, bus_if.lo} !== 64'd0) begin
      failures++; $display("FAIL reset_hilo: got %h expected %h", {bus_if.hi, bus_if.lo}, 64'd0);
    end
    checks++;
    if ({bus_if.busy, bus_if.done} !== 2'b00) begin
      failures++; $display("FAIL reset_busy_done: got %b expected 00", {bus_if.busy, bus_if.done});
    end
    checks++;
    if (bus_if.state_dbg !== 2'd0) begin
      failures++; $display("FAIL reset_state: got %0d expected 0", bus_if.state_dbg);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_multu();
    start_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checks++;
    if (bus_if.busy !== 1'b1) begin
      failures++; $display("FAIL multu_busy_t1: got %b expected 1", bus_if.busy);
    end
    @(negedge clk);
    checks++;
    if ({bus_if.busy, bus_if.done} !== 2'b00) begin
      failures++; $display("FAIL multu_busy_t2: got %b expected 00", {bus_if.busy, bus_if.done});
    end
    @(negedge clk);
    checks++;
    if ({bus_if.hi, bus_if.lo} !== 64'hFFFF_FFFE_0000_0001) begin
      failures++; $display("FAIL multu_result: got %h expected %h", {bus_if.hi, bus_if.lo}, 64'hFFFF_FFFE_0000_0001);
    end
    checks++;
    if (bus_if.done !== 1'b1) begin
      failures++; $display("FAIL multu_done: got %b expected 1", bus_if.done);
    end
    @(negedge clk);
    checks++;
    if (bus_if.done !== 1'b0) begin
      failures++; $display("FAIL multu_done_pulse: got %b expected 0", bus_if.done);
    end
  endtask

  task automatic test_mult_mthi();
    start_op(F_MULT, 32'hFFFF_FFFD, 32'd5);
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_if.hi, bus_if.lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      failures++; $display("FAIL mult_result: got %h expected %h", {bus_if.hi, bus_if.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    end
    start_op(F_HIW, 32'h0000_1234, 32'd0);
    checks++;
    if ({bus_if.hi, bus_if.lo} !== 64'h0000_1234_FFFF_FFF1) begin
      failures++; $display("FAIL mthi_result: got %h expected %h", {bus_if.hi, bus_if.lo}, 64'h0000_1234_FFFF_FFF1);
    end
    checks++;
    if ({bus_if.busy, bus_if.done} !== 2'b00) begin
      failures++; $display("FAIL mthi_busy_done: got %b expected 00", {bus_if.busy, bus_if.done});
    end
  endtask

  task automatic test_back_to_back();
    int n;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    exp_q.push_back({32'd2, 32'd14});
    start_op(F_DIV, 32'hFFFF_FFF9, 32'd2);
    set_req(F_DIV, 32'd100, 32'd7);
    count_busy(n);
    checks++;
    if (n !== 33) begin
      failures++; $display("FAIL div1_busy_cycles: got %0d expected 33", n);
    end
    checks++;
    if (bus_if.done !== 1'b1) begin
      failures++; $display("FAIL div1_done: got %b expected 1", bus_if.done);
    end
    checks++;
    if ({bus_if.hi, bus_if.lo} !== exp_q[0]) begin
      failures++; $display("FAIL div1_result: got %h expected %h", {bus_if.hi, bus_if.lo}, exp_q[0]);
    end
    void'(exp_q.pop_front());
    @(posedge clk);
    @(negedge clk);
    clear_req();
    checks++;
    if (bus_if.busy !== 1'b1) begin
      failures++; $display("FAIL div2_accepted: got %b expected 1", bus_if.busy);
    end
    count_busy(n);
    checks++;
    if (n !== 33) begin
      failures++; $display("FAIL div2_busy_cycles: got %0d expected 33", n);
    end
    checks++;
    if ({bus_if.hi, bus_if.lo} !== exp_q[0]) begin
      failures++; $display("FAIL div2_result: got %h expected %h", {bus_if.hi, bus_if.lo}, exp_q[0]);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic test_div_corner();
    int n;
    start_op(F_DIVU, 32'd100, 32'd0);
    count_busy(n);
    checks++;
    if (n !== 33) begin
      failures++; $display("FAIL divu0_busy_cycles: got %0d expected 33", n);
    end
    checks++;
    if ({bus_if.hi, bus_if.lo} !== 64'h0000_0064_FFFF_FFFF) begin
      failures++; $display("FAIL divu0_result: got %h expected %h", {bus_if.hi, bus_if.lo}, 64'h0000_0064_FFFF_FFFF);
    end
    start_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    checks++;
    if ({bus_if.hi, bus_if.lo} !== 64'h0000_0000_8000_0000) begin
      failures++; $display("FAIL div_ovf_result: got %h expected %h", {bus_if.hi, bus_if.lo}, 64'h0000_0000_8000_0000);
    end
    start_op(F_DIV, 32'hFFFF_FFFB, 32'd0);
    count_busy(n);
    checks++;
    if ({bus_if.hi, bus_if.lo} !== 64'hFFFF_FFFB_FFFF_FFFF) begin
      failures++; $display("FAIL div0_signed_result: got %h expected %h", {bus_if.hi, bus_if.lo}, 64'hFFFF_FFFB_FFFF_FFFF);
    end
  endtask

  task automatic test_flush_abort();
    logic seen_done;
    start_op(F_HIW, 32'hAA, 32'd0);
    start_op(F_LOW, 32'hBB, 32'd0);
    start_op(F_DIVU, 32'd50, 32'd7);
    repeat (9) @(negedge clk);
    bus_if.flush = 1'b1;
    @(negedge clk);
    bus_if.flush = 1'b0;
    checks++;
    if ({bus_if.busy, bus_if.state_dbg} !== 3'b000) begin
      failures++; $display("FAIL flush_idle: got %b expected 000", {bus_if.busy, bus_if.state_dbg});
    end
    seen_done = 1'b0;
    repeat (40) begin
      if (bus_if.done === 1'b1) seen_done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen_done !== 1'b0) begin
      failures++; $display("FAIL flush_no_done: got %b expected 0", seen_done);
    end
    checks++;
    if ({bus_if.hi, bus_if.lo} !== {32'hAA, 32'hBB}) begin
      failures++; $display("FAIL flush_hilo_kept: got %h expected %h", {bus_if.hi, bus_if.lo}, {32'hAA, 32'hBB});
    end
  endtask

  task automatic test_reset_mid();
    int n;
    start_op(F_DIVU, 32'd50, 32'd7);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    checks++;
    if ({bus_if.hi, bus_if.lo, bus_if.busy} !== 65'd0) begin
      failures++; $display("FAIL reset_mid: got %h expected 0", {bus_if.hi, bus_if.lo, bus_if.busy});
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    start_op(F_DIVU, 32'd50, 32'd7);
    count_busy(n);
    checks++;
    if ({bus_if.hi, bus_if.lo} !== {32'd1, 32'd7}) begin
      failures++; $display("FAIL divu_after_reset: got %h expected %h", {bus_if.hi, bus_if.lo}, {32'd1, 32'd7});
    end
  endtask

  task automatic test_flush_accept_and_priority();
    int n;
    start_op(F_LOW, 32'h1111, 32'd0);
    set_req(F_LOW, 32'h5555, 32'd0);
    bus_if.flush = 1'b1;
    @(negedge clk);
    bus_if.flush = 1'b0;
    clear_req();
    checks++;
    if (bus_if.lo !== 32'h1111) begin
      failures++; $display("FAIL flush_blocks_mtlo: got %h expected %h", bus_if.lo, 32'h1111);
    end
    start_op(F_HIW, 32'h77, 32'd0);
    start_op(F_DIV | F_HIW, 32'd20, 32'd3);
    checks++;
    if ({bus_if.busy, bus_if.hi} !== {1'b1, 32'h77}) begin
      failures++; $display("FAIL div_over_hiw_t1: got %h expected %h", {bus_if.busy, bus_if.hi}, {1'b1, 32'h77});
    end
    count_busy(n);
    checks++;
    if ({bus_if.hi, bus_if.lo} !== {32'd2, 32'd6}) begin
      failures++; $display("FAIL div_over_hiw_result: got %h expected %h", {bus_if.hi, bus_if.lo}, {32'd2, 32'd6});
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_mthi();
    test_back_to_back();
    test_div_corner();
    test_flush_abort();
    test_reset_mid();
    test_flush_accept_and_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- HI/LO multiply/divide unit in the EX stage, directly downstream of the ID control decoder.
- Consumes the decoded op flags (is_mult, is_multu, is_div, is_divu, hi_wen, lo_wen) plus rs/rt operands, and owns the architectural HI/LO registers.
- Multiply has a fixed multi-cycle latency; divide is an iterative radix-2 restoring divider.
- Asserts busy so the pipeline stalls until results are ready for mfhi/mflo/mul.

Parameters:
- MUL_LAT, 2, cycles from accept edge to HI/LO update for mult/multu; legal range 1..4.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- req_valid  in  1  EX holds a valid instruction carrying op flags/operands this cycle
- is_mult  in  1  signed 32x32 multiply (also used for mul)
- is_multu  in  1  unsigned 32x32 multiply
- is_div  in  1  signed divide
- is_divu  in  1  unsigned divide
- hi_wen  in  1  mthi
- lo_wen  in  1  mtlo
- a  in  32  rs_data (dividend / multiplicand / mthi/mtlo source)
- b  in  32  rt_data (divisor / multiplier)
- flush  in  1  exception/eret flush; aborts any op
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  operation in flight; EX must stall and hold inputs
- done  out  1  one-cycle pulse after a mult/div result is written

Interface:
- One clock; reset is asynchronous and active-low.

Behaviour:
- Reset (resetn=0, async): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
- Accept condition: edge where req_valid & ~busy & ~flush. This edge is T0.
- Flag priority if multiple flags are set: div > divu > mult > multu > hi_wen > lo_wen. The decoder guarantees one-hot.
- mthi/mtlo: hi (or lo) <= a at T0. No busy, no done.
- States: IDLE, MUL, DIV, FIX.
- Multiply:
  - At T0: latch sign-handled operands; state <= MUL; counter <= 1.
  - 64-bit product passes through MUL_LAT register stages.
  - At edge T0+MUL_LAT: {hi,lo} <= product; state <= IDLE.
  - busy=1 during cycles T0+1 .. T0+MUL_LAT-1. For MUL_LAT=1, busy never rises.
  - done=1 for the single cycle after the write.
- Divide:
  - At T0: latch |a|, |b| (raw values for divu), quotient sign = a[31]^b[31], remainder sign = a[31] (signed only); counter <= 0; state <= DIV.
  - Edges T0+1..T0+32: one restoring iteration each (shift remainder left, trial-subtract divisor, set quotient bit); counter increments; counter==31 moves to FIX.
  - Edge T0+33 (FIX): apply signs; lo <= quotient, hi <= remainder; state <= IDLE.
  - busy=1 during cycles T0+1..T0+33. done pulses during cycle T0+34.
- Divide by zero: completes with the same latency; lo <= 32'hFFFF_FFFF, hi <= a (raw operand), for both div and divu.
- div 0x8000_0000 / 0xFFFF_FFFF: lo <= 0x8000_0000, hi <= 0 (magnitude wraps naturally). No exception.
- busy is a registered output, never combinational from inputs.
- Requests while busy are ignored. EX holds the instruction; it is re-presented and accepted on the first edge with busy=0.
- flush:
  - In any non-IDLE state: state <= IDLE at the next edge. HI/LO are unchanged, no done, busy=0 from the following cycle.
  - flush in the accept cycle: nothing is accepted, including mthi/mtlo.
- Reset asserted mid-operation: immediate return to the reset values; the partial result is discarded.
- hi/lo are stable and never partially updated; both change only on the same write edge.

Test Plan:
- multu a=0xFFFF_FFFF b=0xFFFF_FFFF, MUL_LAT=2 -> busy high 1 cycle; at T0+2 hi=0xFFFF_FFFE, lo=0x0000_0001; done pulse during cycle T0+3.
- mult a=0xFFFF_FFFD (-3) b=5 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFF1; then mthi a=0x1234 -> hi=0x1234 next edge, lo unchanged, busy stays 0.
- div a=0xFFFF_FFF9 (-7) b=2 -> busy high for exactly 33 cycles; lo=0xFFFF_FFFD, hi=0xFFFF_FFFF at T0+33; a second div held during busy is accepted only after busy falls.
- divu a=100 b=0 -> lo=0xFFFF_FFFF, hi=0x64 after 33 cycles. div 0x8000_0000/0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
- Prior hi=0xAA, lo=0xBB; start divu 50/7; flush at cycle T0+10 -> busy=0 from T0+11, hi=0xAA, lo=0xBB, no done. Repeat with resetn pulsed low mid-divide -> hi=lo=0, busy=0 immediately.
- flush and req_valid with lo_wen in the same cycle -> lo unchanged. Simultaneous is_div and hi_wen -> divide performed, hi not written at T0.
